div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU. Lives in the EX stage.
- Acts as the requester side of the pipeline stall/flush interface: it raises the EX stall request toward the pipeline controller while busy, and obeys the controller's flush.
- Result is {remainder, quotient}, written by EX to HI/LO.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  pipeline flush from the controller (exception or eret)
- start_i  in  1  EX holds a DIV/DIVU; held high for as long as EX stalls on it
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend (rs)
- opdata2_i  in  32  divisor (rt)
- result_o  out  64  [63:32] remainder, [31:0] quotient
- ready_o  out  1  result valid
- stallreq_o  out  1  stall request to the controller (EX-level stall)

Behaviour:
- Reset (async) puts the block in FREE with result_o = 0, ready_o = 0, counter = 0 and all internal registers = 0. Reset may arrive in any state, mid-division included; the block is in FREE at the first clock edge after rst falls.
- stallreq_o is combinational: start_i & ~ready_o & ~flush_i.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i = 1, flush_i = 0, divisor != 0: latch the magnitudes of both operands, their signs and signed_i; counter <= 0; go to ON.
  - start_i = 1, flush_i = 0, divisor = 0: go to BYZERO.
  - Otherwise stay in FREE, ready_o = 0, result_o = 0.
- BYZERO: go to END with quotient = 0 and remainder = 0.
- ON:
  - Restoring radix-2 step each cycle on a 65-bit partial register {rem, quo}: shift left 1, trial-subtract the divisor from the upper 33 bits. If non-negative, keep the difference and set the quotient LSB to 1; else set it to 0.
  - counter increments each cycle. After the step with counter = 31, go to END.
  - Sign fix applied on entry to END: negate the quotient if signed_i and the operand signs differ; negate the remainder if signed_i and the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- END:
  - ready_o = 1 and result_o is driven from the registered result.
  - Stay in END while start_i = 1; this covers a pipeline stalled by a later load or outside stall.
  - When start_i = 0, go to FREE with ready_o = 0 and result_o = 0 on the next cycle.
- Latency: start_i sampled in FREE at edge 0 puts ready_o = 1 in the cycle after edge 33 (32 ON cycles plus 1 transition). Divide-by-zero gives ready_o after edge 2. stallreq_o is high during every cycle before that.
- Operands are sampled only on FREE→ON/BYZERO; later changes on opdata*_i are ignored.
- flush_i = 1 in any state: go to FREE at the next edge, ready_o <= 0, result_o <= 0, in-progress work discarded. Flush has priority over start_i in the same cycle.
- start_i falling in ON or BYZERO (annulled instruction) is treated like a flush: go to FREE, discard.
- A new division starts only from FREE. Back-to-back DIVs therefore need one FREE cycle between them.

Test Plan:
- DIVU 100 / 7, start_i held: stallreq_o = 1 for 33 cycles, then ready_o = 1 with result_o = 0x00000002_0000000E; drop start_i → FREE next cycle, result_o = 0.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7 / −2 → 0x00000001_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- DIVU 5 / 0 → ready_o after 2 cycles, result_o = 0; stallreq_o drops the same cycle ready_o rises.
- flush_i pulsed at ON counter = 10 → FREE next cycle, ready_o never asserts. A new DIVU 9 / 3 issued afterwards returns 0x00000000_00000003. rst asserted mid-ON → all outputs 0 immediately.
- In END, hold start_i for 5 extra cycles and change opdata*_i → ready_o and result_o stay stable; the operand changes have no effect.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for MIPS DIV/DIVU in EX.
// Produces {remainder, quotient}, stalls EX while busy and obeys pipeline flush.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    // Two's-complement negation.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

    // Unsigned magnitude of an operand; only signed operations fold the sign.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                    input logic is_signed);
        return (is_signed && x[DATA_W-1]) ? negate(x) : x;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Partial register {rem, quo}; the remainder never exceeds the divisor
    // between steps, so the extra shifted-out bit lives only in part_sh.
    logic [2*DATA_W-1:0]    part_q, part_d;
    logic [DATA_W-1:0]      dvsr_q, dvsr_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]    res_q, res_d;
    logic                   ready_q, ready_d;
    logic [2*DATA_W-1:0]    result_q, result_d;

    logic [2*DATA_W:0]      part_sh;
    logic                   trial_ge;
    logic [DATA_W-1:0]      trial_diff;
    logic [2*DATA_W-1:0]    part_step;
    logic [DATA_W-1:0]      quo_fix;
    logic [DATA_W-1:0]      rem_fix;

    // One restoring step: shift, trial-subtract the divisor from the upper bits.
    always_comb begin
        part_sh    = {part_q, 1'b0};
        trial_ge   = (part_sh[2*DATA_W:DATA_W] >= {1'b0, dvsr_q});
        trial_diff = part_sh[DATA_W-1+DATA_W:DATA_W] - dvsr_q;
        part_step  = trial_ge ? {trial_diff, part_sh[DATA_W-1:1], 1'b1}
                              : part_sh[2*DATA_W-1:0];
        quo_fix    = neg_quo_q ? negate(part_step[DATA_W-1:0]) : part_step[DATA_W-1:0];
        rem_fix    = neg_rem_q ? negate(part_step[2*DATA_W-1:DATA_W])
                               : part_step[2*DATA_W-1:DATA_W];
    end

    // Next-state and next-register computation for the divider FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        ready_d   = 1'b0;
        result_d  = '0;

        if (flush_i) begin
            state_d = ST_FREE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state_d = ST_BYZERO;
                        end else begin
                            state_d   = ST_ON;
                            cnt_d     = '0;
                            part_d    = {{DATA_W{1'b0}}, magnitude(opdata1_i, signed_i)};
                            dvsr_d    = magnitude(opdata2_i, signed_i);
                            neg_quo_d = signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem_d = signed_i & opdata1_i[DATA_W-1];
                        end
                    end
                end
                ST_BYZERO: begin
                    // A dropped start means EX annulled the instruction.
                    if (!start_i) begin
                        state_d = ST_FREE;
                    end else begin
                        state_d = ST_END;
                        res_d   = '0;
                    end
                end
                ST_ON: begin
                    if (!start_i) begin
                        state_d = ST_FREE;
                        cnt_d   = '0;
                    end else begin
                        part_d = part_step;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_END;
                            res_d   = {rem_fix, quo_fix};
                        end
                    end
                end
                ST_END: begin
                    // Hold the result while EX is still stalled on this op.
                    if (start_i) begin
                        ready_d  = 1'b1;
                        result_d = res_q;
                    end else begin
                        state_d = ST_FREE;
                    end
                end
                default: begin
                    state_d = ST_FREE;
                end
            endcase
        end
    end

    // State and datapath registers, all cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FREE;
            cnt_q     <= '0;
            part_q    <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~flush_i;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector scoreboard bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected result and expected busy (stalled) negedge count.
    logic [63:0] exp_q[$];
    int          busy_q[$];

    int          tests;
    int          fails;
    logic        expect_hold;
    logic        done;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Monitor: samples on negedge, pops the scoreboard on each ready rise.
    initial begin
        logic [63:0] e;
        logic [63:0] last_res;
        logic        prev_ready;
        int          busy;
        int          b;
        logic        done_chk;
        tests = 0; fails = 0;
        prev_ready = 1'b0; busy = 0; last_res = '0; done_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_ready", {63'd0, ready_o}, 64'd0);
                chk("reset_result", result_o, 64'd0);
                chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
                prev_ready = 1'b0;
                busy = 0;
            end else begin
                if (flush_i && start_i)
                    chk("flush_stall", {63'd0, stallreq_o}, 64'd0);
                if (start_i && !ready_o && !flush_i) begin
                    busy++;
                    chk("busy_stall", {63'd0, stallreq_o}, 64'd1);
                end
                if (busy == 60) begin
                    chk("timeout_ready", {63'd0, ready_o}, 64'd1);
                    busy = 0;
                end
                if (ready_o && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        b = busy_q.pop_front();
                        chk("result", result_o, e);
                        chk("latency", 64'(busy), 64'(b));
                        chk("stall_drop", {63'd0, stallreq_o}, 64'd0);
                        last_res = e;
                    end
                end else if (ready_o && prev_ready) begin
                    chk("hold_result", result_o, last_res);
                end else if (!ready_o && prev_ready) begin
                    chk("release_result", result_o, 64'd0);
                end
                if (expect_hold)
                    chk("hold_ready", {63'd0, ready_o}, 64'd1);
                if (!start_i || flush_i || ready_o)
                    busy = 0;
                prev_ready = ready_o;
            end
            if (done && !done_chk) begin
                chk("queue_empty", 64'(exp_q.size()), 64'd0);
                done_chk = 1'b1;
            end
        end
    end

    // Wait (bounded) for ready_o after the last edge, sampled #1 after posedge.
    task automatic wait_ready();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (ready_o) break;
        end
    endtask

    // Issue one division, hold it extra cycles in END, optionally reset in END.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] d,
                           input logic [63:0] res, input int busy_cycles,
                           input int extra, input logic rst_end);
        @(posedge clk); #1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = d;
        start_i   = 1'b1;
        exp_q.push_back(res);
        busy_q.push_back(busy_cycles);
        wait_ready();
        expect_hold = ready_o;
        for (int i = 0; i < extra; i++) begin
            @(posedge clk); #1;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = ~signed_i;
        end
        expect_hold = 1'b0;
        start_i = 1'b0;
        if (rst_end) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0; expect_hold = 1'b0; done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_div(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34, 0, 1'b0);
        run_div(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
        run_div(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0, 1'b0);
        run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34, 0, 1'b0);
        run_div(1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 34, 0, 1'b0);
        run_div(1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 3,  0, 1'b0);
        run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34, 0, 1'b0);
        run_div(1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 34, 0, 1'b0);
        run_div(1'b0, 32'd123456789,  32'd1000,     64'h00000315_0001E240, 34, 0, 1'b0);
        run_div(1'b1, 32'd5,          32'd0,        64'h00000000_00000000, 3,  0, 1'b0);
        run_div(1'b0, 32'd1000,       32'd10,       64'h00000000_00000064, 34, 5, 1'b0);
        run_div(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34, 2, 1'b1);

        // Flush at ON counter 10 while EX keeps start high with a new DIVU 9/3.
        @(posedge clk); #1;
        signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
        exp_q.push_back(64'h00000000_00000003);
        busy_q.push_back(34);
        @(posedge clk); #1;
        flush_i = 1'b0;
        wait_ready();
        start_i = 1'b0;

        // Reset in the middle of ON, then a fresh division.
        @(posedge clk); #1;
        signed_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_div(1'b0, 32'd9,          32'd3,        64'h00000000_00000003, 34, 0, 1'b0);

        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
